// File: rtl/iq_burst_player.sv
// I/Q burst replay source: captures a dump-path burst into local memory and
// replays it on command as a paced stream, optionally looping.
module iq_burst_player #(
    parameter int WIDTH = 9,
    parameter int DEPTH = 120,
    parameter int AW    = 7,
    parameter int DIV_W = 4
) (
    input  logic             clk,
    input  logic             rstb,
    input  logic [WIDTH-1:0] in_data_i,
    input  logic [WIDTH-1:0] in_data_q,
    input  logic             in_data_en,
    input  logic             in_done,
    input  logic             start,
    input  logic             stop,
    input  logic             loop_en,
    input  logic [DIV_W-1:0] rate_div,
    output logic [WIDTH-1:0] out_i,
    output logic [WIDTH-1:0] out_q,
    output logic             out_en,
    output logic             out_done,
    output logic             busy,
    output logic [AW-1:0]    burst_len,
    output logic             overflow
);

    // state | meaning
    // IDLE  | loading allowed, outputs held at zero, waiting for start
    // PLAY  | replaying mem[0..burst_len-1], one sample every rate_div+1 cycles
    typedef enum logic {IDLE, PLAY} state_t;

    localparam logic [AW-1:0] DEPTH_A = AW'(DEPTH);

    state_t                 state;
    logic [2*WIDTH-1:0]     mem [DEPTH];
    logic                   ld_en;
    logic                   ld_done;
    logic [2*WIDTH-1:0]     ld_word;
    logic [AW-1:0]          wptr;
    logic [AW-1:0]          rptr;
    logic [DIV_W-1:0]       pace;
    logic                   load_open;
    logic                   wr_en;
    logic [AW-1:0]          wr_addr;

    assign busy = (state == PLAY);

    always_comb begin
        wr_en   = 1'b0;
        wr_addr = wptr;
        if (ld_en && state == IDLE) begin
            if (!load_open) begin
                wr_en   = 1'b1;
                wr_addr = '0;
            end else if (wptr != DEPTH_A) begin
                wr_en = 1'b1;
            end
        end
    end

    // Storage has no reset; burst_len=0 keeps stale contents unreachable.
    always_ff @(posedge clk) begin
        if (rstb && wr_en) begin
            mem[wr_addr] <= ld_word;
        end
    end

    always_ff @(posedge clk) begin
        if (!rstb) begin
            state     <= IDLE;
            ld_en     <= 1'b0;
            ld_done   <= 1'b0;
            ld_word   <= '0;
            wptr      <= '0;
            rptr      <= '0;
            pace      <= '0;
            load_open <= 1'b0;
            burst_len <= '0;
            overflow  <= 1'b0;
            out_en    <= 1'b0;
            out_done  <= 1'b0;
            out_i     <= '0;
            out_q     <= '0;
        end else begin
            ld_en   <= in_data_en;
            ld_done <= in_done;
            ld_word <= {in_data_i, in_data_q};

            if (ld_en) begin
                if (state != IDLE) begin
                    overflow <= 1'b1;
                end else if (!load_open) begin
                    wptr      <= AW'(1);
                    overflow  <= 1'b0;
                    load_open <= !ld_done;
                    if (ld_done) burst_len <= AW'(1);
                end else begin
                    if (wptr == DEPTH_A) overflow <= 1'b1;
                    else                 wptr     <= wptr + 1'b1;
                    if (ld_done) begin
                        load_open <= 1'b0;
                        burst_len <= (wptr == DEPTH_A) ? DEPTH_A : wptr + 1'b1;
                    end
                end
            end

            case (state)
                IDLE: begin
                    out_en   <= 1'b0;
                    out_done <= 1'b0;
                    out_i    <= '0;
                    out_q    <= '0;
                    if (start && !load_open && burst_len != '0) begin
                        state <= PLAY;
                        rptr  <= '0;
                        pace  <= '0;
                    end
                end
                PLAY: begin
                    if (stop) begin
                        state    <= IDLE;
                        out_en   <= 1'b0;
                        out_done <= 1'b0;
                        out_i    <= '0;
                        out_q    <= '0;
                    end else if (pace != '0) begin
                        pace     <= pace - 1'b1;
                        out_en   <= 1'b0;
                        out_done <= 1'b0;
                        out_i    <= '0;
                        out_q    <= '0;
                    end else begin
                        out_en         <= 1'b1;
                        {out_i, out_q} <= mem[rptr];
                        pace           <= rate_div;
                        if (rptr == burst_len - 1'b1) begin
                            out_done <= 1'b1;
                            rptr     <= '0;
                            if (!loop_en) state <= IDLE;
                        end else begin
                            out_done <= 1'b0;
                            rptr     <= rptr + 1'b1;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_iq_burst_player.sv
// Self-checking bench for iq_burst_player: scoreboard of expected replay
// samples built from the loaded data, plus per-cycle pacing/status checks.
module tb_iq_burst_player;

    logic       clk;
    logic       rstb;
    logic [8:0] in_data_i;
    logic [8:0] in_data_q;
    logic       in_data_en;
    logic       in_done;
    logic       start;
    logic       stop;
    logic       loop_en;
    logic [3:0] rate_div;
    logic [8:0] out_i;
    logic [8:0] out_q;
    logic       out_en;
    logic       out_done;
    logic       busy;
    logic [6:0] burst_len;
    logic       overflow;

    int errors = 0;
    int checks = 0;
    bit mon_on = 1'b1;
    logic [17:0] exp_mem [128];
    logic [18:0] exp_q [$];

    iq_burst_player dut (
        .clk(clk), .rstb(rstb),
        .in_data_i(in_data_i), .in_data_q(in_data_q),
        .in_data_en(in_data_en), .in_done(in_done),
        .start(start), .stop(stop), .loop_en(loop_en), .rate_div(rate_div),
        .out_i(out_i), .out_q(out_q), .out_en(out_en), .out_done(out_done),
        .busy(busy), .burst_len(burst_len), .overflow(overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Scoreboard consumer: every emitted sample must match the queue head.
    always @(negedge clk) begin
        if (mon_on && rstb && out_en) begin
            logic [18:0] e;
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL sample_unexpected got done=%0b i=%h q=%h, required no sample",
                         out_done, out_i, out_q);
            end else begin
                e = exp_q.pop_front();
                if ({out_done, out_i, out_q} !== e) begin
                    errors++;
                    $display("FAIL sample_data got done=%0b i=%h q=%h, required done=%0b i=%h q=%h",
                             out_done, out_i, out_q, e[18], e[17:9], e[8:0]);
                end
            end
        end
    end

    function automatic logic [17:0] gen(input int mode, input int j);
        logic [8:0] gi;
        logic [8:0] gq;
        if (mode == 0) begin
            gi = 9'(j);
            gq = ~9'(j);
        end else begin
            gi = 9'(j * 5 + mode * 17);
            gq = ~9'(j * 7 + mode);
        end
        return {gi, gq};
    endfunction

    task automatic load_burst(input int n, input int mode);
        for (int j = 0; j < n; j++) begin
            @(negedge clk);
            in_data_en = 1'b1;
            {in_data_i, in_data_q} = gen(mode, j);
            in_done = (j == n - 1);
            if (j < 120) exp_mem[j] = gen(mode, j);
        end
        @(negedge clk);
        in_data_en = 1'b0;
        in_done    = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    task automatic pulse_start();
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    // Starts playback and tracks it cycle by cycle; c counts cycles after PLAY entry.
    task automatic run_play(input int n, input int rd, input int nsamp,
                            input int stop_c, input int loopclr_c, input string name);
        int limit;
        int dones;
        int exp_dones;
        bit exp_en;
        dones = 0;
        exp_dones = 0;
        rate_div = 4'(rd);
        for (int k = 0; k < nsamp; k++) begin
            exp_q.push_back({1'b0 | ((k % n) == n - 1), exp_mem[k % n]});
            if ((k % n) == n - 1) exp_dones++;
        end
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        checks++;
        if (busy !== 1'b1 || out_en !== 1'b0) begin
            errors++;
            $display("FAIL %s_entry got busy=%0b out_en=%0b, required busy=1 out_en=0", name, busy, out_en);
        end
        limit = (stop_c > 0) ? stop_c : nsamp * (rd + 1) + 2;
        for (int c = 1; c <= limit; c++) begin
            @(negedge clk);
            if (stop_c > 0 && c == stop_c) begin
                checks++;
                if (out_en !== 1'b0 || out_done !== 1'b0 || busy !== 1'b0) begin
                    errors++;
                    $display("FAIL %s_stop got en=%0b done=%0b busy=%0b, required all 0",
                             name, out_en, out_done, busy);
                end
                stop = 1'b0;
                break;
            end
            exp_en = ((c - 1) % (rd + 1) == 0) && (c <= nsamp * (rd + 1));
            if (out_done) dones++;
            checks++;
            if (out_en !== exp_en) begin
                errors++;
                $display("FAIL %s_pace cycle %0d got out_en=%0b, required %0b", name, c, out_en, exp_en);
            end
            if (!exp_en && (out_i !== 9'd0 || out_q !== 9'd0 || out_done !== 1'b0)) begin
                errors++;
                $display("FAIL %s_idle_zero cycle %0d got i=%h q=%h done=%0b, required 0",
                         name, c, out_i, out_q, out_done);
            end
            if (c + 1 == stop_c) stop = 1'b1;
            if (c == loopclr_c) loop_en = 1'b0;
        end
        checks++;
        if (busy !== 1'b0 || exp_q.size() != 0 || (stop_c == 0 && dones != exp_dones)) begin
            errors++;
            $display("FAIL %s_end got busy=%0b left=%0d dones=%0d, required busy=0 left=0 dones=%0d",
                     name, busy, exp_q.size(), dones, exp_dones);
        end
        exp_q.delete();
    endtask

    task automatic test_reset();
        rstb = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if ({out_en, out_done, busy, overflow} !== 4'b0 || burst_len !== 7'd0 ||
            out_i !== 9'd0 || out_q !== 9'd0) begin
            errors++;
            $display("FAIL reset_outputs got en=%0b done=%0b busy=%0b ovf=%0b len=%0d, required all 0",
                     out_en, out_done, busy, overflow, burst_len);
        end
        rstb = 1'b1;
        pulse_start();
        @(negedge clk);
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL reset_start_empty got busy=%0b, required 0", busy);
        end
    endtask

    task automatic test_full_burst();
        load_burst(120, 0);
        checks++;
        if (burst_len !== 7'd120 || overflow !== 1'b0) begin
            errors++;
            $display("FAIL full_len got len=%0d ovf=%0b, required 120 0", burst_len, overflow);
        end
        run_play(120, 0, 120, 0, 0, "full");
    endtask

    task automatic test_rate_div();
        load_burst(5, 1);
        checks++;
        if (burst_len !== 7'd5) begin
            errors++;
            $display("FAIL rate_len got %0d, required 5", burst_len);
        end
        run_play(5, 2, 5, 0, 0, "rate");
    endtask

    task automatic test_overflow();
        load_burst(121, 2);
        checks++;
        if (burst_len !== 7'd120 || overflow !== 1'b1) begin
            errors++;
            $display("FAIL ovf_set got len=%0d ovf=%0b, required 120 1", burst_len, overflow);
        end
        load_burst(3, 3);
        checks++;
        if (burst_len !== 7'd3 || overflow !== 1'b0) begin
            errors++;
            $display("FAIL ovf_clear got len=%0d ovf=%0b, required 3 0", burst_len, overflow);
        end
        run_play(3, 0, 3, 0, 0, "ovf_replay");
    endtask

    task automatic test_loop();
        load_burst(4, 4);
        loop_en = 1'b1;
        run_play(4, 0, 16, 0, 14, "loop");
        loop_en = 1'b0;
    endtask

    task automatic test_stop_restart();
        load_burst(120, 5);
        run_play(120, 0, 49, 50, 0, "stop");
        run_play(120, 0, 120, 0, 0, "restart");
    endtask

    task automatic test_busy_load_reset();
        mon_on = 1'b0;
        rate_div = 4'd0;
        pulse_start();
        repeat (8) @(negedge clk);
        in_data_en = 1'b1;
        in_done    = 1'b1;
        {in_data_i, in_data_q} = 18'h15A5A;
        @(negedge clk);
        in_data_en = 1'b0;
        in_done    = 1'b0;
        repeat (2) @(negedge clk);
        checks++;
        if (overflow !== 1'b1 || burst_len !== 7'd120 || busy !== 1'b1) begin
            errors++;
            $display("FAIL busy_load got ovf=%0b len=%0d busy=%0b, required 1 120 1",
                     overflow, burst_len, busy);
        end
        rstb = 1'b0;
        @(negedge clk);
        checks++;
        if ({out_en, out_done, busy, overflow} !== 4'b0 || burst_len !== 7'd0 ||
            out_i !== 9'd0 || out_q !== 9'd0) begin
            errors++;
            $display("FAIL midplay_reset got en=%0b done=%0b busy=%0b ovf=%0b len=%0d i=%h, required all 0",
                     out_en, out_done, busy, overflow, burst_len, out_i);
        end
        rstb = 1'b1;
        pulse_start();
        @(negedge clk);
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL reset_start_ignored got busy=%0b, required 0", busy);
        end
        mon_on = 1'b1;
    endtask

    task automatic test_start_while_open();
        @(negedge clk);
        in_data_en = 1'b1;
        {in_data_i, in_data_q} = gen(6, 0);
        exp_mem[0] = gen(6, 0);
        @(negedge clk);
        in_data_en = 1'b0;
        repeat (2) @(negedge clk);
        start = 1'b1;
        repeat (2) @(negedge clk);
        start = 1'b0;
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL open_start got busy=%0b, required 0", busy);
        end
        in_data_en = 1'b1;
        in_done    = 1'b1;
        {in_data_i, in_data_q} = gen(6, 1);
        exp_mem[1] = gen(6, 1);
        @(negedge clk);
        in_data_en = 1'b0;
        in_done    = 1'b0;
        repeat (2) @(negedge clk);
        checks++;
        if (burst_len !== 7'd2) begin
            errors++;
            $display("FAIL open_len got %0d, required 2", burst_len);
        end
        run_play(2, 1, 2, 0, 0, "open_replay");
    endtask

    initial begin
        rstb = 1'b0;
        in_data_i = '0;
        in_data_q = '0;
        in_data_en = 1'b0;
        in_done = 1'b0;
        start = 1'b0;
        stop = 1'b0;
        loop_en = 1'b0;
        rate_div = '0;
        test_reset();
        test_full_burst();
        test_rate_div();
        test_overflow();
        test_loop();
        test_stop_restart();
        test_busy_load_reset();
        test_start_while_open();
        repeat (3) @(negedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
